core_alu_arb: RTL
=================

# core_alu_arb

Two-requester arbiter and sequencer for the core's shared combinational ALU. Accepts ALU operations from the instruction execute unit (requester 0) and the auxiliary math port (requester 1). Grants round-robin, holds operands stable on the ALU for one cycle, or for `MC_CYCLES` cycles for MUL/DIV to meet the multicycle-path constraint. Returns a registered, tagged result. Sits between the core execute logic and `core_alu`; it is the only driver of the ALU inputs.

## Interface
- `MC_CYCLES`, 2: EXEC cycles for ALU_MUL/ALU_DIV; legal range 1..15.
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `reqN_valid_i`  in  1  request from requester N (N = 0, 1).
- `reqN_opcode_i`  in  5  ALU opcode (ALU_* codes).
- `reqN_op1_i`, `reqN_op2_i`  in  8  operands.
- `reqN_cy_i`, `reqN_ac_i`, `reqN_ov_i`  in  1  incoming PSW flags.
- `reqN_ready_o`  out  1  request N accepted on this edge when high together with valid.
- `alu_en_o`  out  1  ALU enable.
- `alu_operand1_o`, `alu_operand2_o`  out  8  operands to the ALU.
- `alu_opcode_o`  out  5  opcode to the ALU.
- `alu_cy_o`, `alu_ac_o`, `alu_ov_o`  out  1  flags to the ALU.
- `alu_result_i`  in  16  ALU result.
- `alu_cy_i`, `alu_ac_i`, `alu_ov_i`  in  1  ALU flag outputs.
- `rsp_valid_o`  out  1  one-cycle response strobe.
- `rsp_id_o`  out  1  requester that owns the response.
- `rsp_result_o`  out  16  registered result.
- `rsp_cy_o`, `rsp_ac_o`, `rsp_ov_o`  out  1  registered flags.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Acceptance is allowed in IDLE and RESP only. `reqN_ready_o` is combinational and is high for the granted requester only. At most one ready is high per cycle.
- Arbitration is round-robin using a 1-bit `last` pointer, reset to 1, so requester 0 wins first.
  - If both are valid, grant `~last`.
  - If only one is valid, grant it.
  - Update `last` on each accept.
- On accept: latch opcode, operands, flags and id into the operand register; load `cnt` with `MC_CYCLES-1` if the opcode is ALU_MUL/ALU_DIV, else 0; go to EXEC.
- EXEC:
  - `alu_en_o`=1, and the ALU inputs are driven from the operand register.
  - If `cnt`≠0, decrement and stay.
  - If `cnt`=0, capture `alu_result_i` and the flags into the response register and go to RESP.
- RESP:
  - `rsp_valid_o`=1 for exactly this cycle.
  - On a new accept, go to EXEC; otherwise go to IDLE.
- There is no response backpressure; requesters must sample `rsp_*` on `rsp_valid_o`.
- Outside EXEC, `alu_en_o`=0 and the ALU operand/opcode/flag outputs hold their last latched values. The ALU then outputs a zero result with pass-through flags, which is ignored.
- `rsp_result_o` and the `rsp_*` flags hold their value until the next capture. `rsp_id_o` is valid only with `rsp_valid_o`.
- Opcode values are not checked; unknown opcodes take 1 EXEC cycle, and whatever the ALU returns is passed back.

## Timing
- Accept in cycle 0 (edge at end of cycle 0):
  - single-cycle op: EXEC in cycle 1, `rsp_valid_o` in cycle 2;
  - MUL/DIV: EXEC in cycles 1..`MC_CYCLES`, response in cycle `MC_CYCLES`+1.
- Peak throughput is one single-cycle op per 2 cycles, using accept-in-RESP.
- Reset values:
  - all `*_ready_o`, `alu_en_o` and `rsp_valid_o` are 0;
  - `rsp_id_o`, `rsp_result_o`, the `rsp_*` flags, the `alu_*` operand/opcode/flag outputs and `cnt` are 0;
  - `last`=1; state is IDLE.
- Reset asserted in any state clears immediately. An in-flight operation is dropped with no response. The first accept after release goes to requester 0.
- A request valid during EXEC is not accepted; the requester holds valid and its inputs.

## Structure
- ALU opcode constants (ALU_MUL, ALU_DIV, etc.) come from the shared instruction-set define file. State encodings and the `MC_CYCLES` range check belong in the same shared package.
- No sub-module is required. The round-robin grant is small enough to stay inline. Instantiate alongside `core_alu` in the core top.

## Test plan
- Req0 ADD, op1=0x3A, op2=0xC7, cy=0, accepted in cycle 0 -> `rsp_valid_o` in cycle 2 with id=0, result=0x0001, cy=1, ac=1, ov=0.
- Req1 MUL 0x10×0x20 with `MC_CYCLES`=2 -> `alu_en_o` high in cycles 1–2; response in cycle 3 with id=1, result=0x0200, cy=0, ac=0, ov=1.
- Req0 DIV, op2=0x00 -> result=0x0000, ov=1, cy=0; response after `MC_CYCLES`+1 cycles.
- Both requesters held valid with ADD from reset -> grants 0,1,0,1, a response every 2 cycles, ids alternating starting with 0.
- Req0 INC held valid continuously, op1=0xFF, cy=1, ac=0, ov=1 -> accepted every 2nd cycle (in RESP); each result=0x0000 with flags passed through as cy=1, ac=0, ov=1.
- `rst_i` pulsed during a MUL's EXEC cycle 1 -> all outputs go to reset values immediately and no `rsp_valid_o` occurs. After release, with both valid, requester 0 is granted first.

Source files
------------

// File: rtl/core_alu_arb_pkg.sv
// rtl/core_alu_arb_pkg.sv - ALU opcodes, arbiter state encoding and parameter checks
package core_alu_arb_pkg;

    localparam logic [4:0] ALU_NOP  = 5'h00;
    localparam logic [4:0] ALU_ADD  = 5'h01;
    localparam logic [4:0] ALU_ADDC = 5'h02;
    localparam logic [4:0] ALU_SUB  = 5'h03;
    localparam logic [4:0] ALU_INC  = 5'h04;
    localparam logic [4:0] ALU_DEC  = 5'h05;
    localparam logic [4:0] ALU_AND  = 5'h06;
    localparam logic [4:0] ALU_OR   = 5'h07;
    localparam logic [4:0] ALU_XOR  = 5'h08;
    localparam logic [4:0] ALU_MUL  = 5'h0A;
    localparam logic [4:0] ALU_DIV  = 5'h0B;

    localparam int MC_CYCLES_MIN = 1;
    localparam int MC_CYCLES_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // MUL/DIV are timed as multicycle paths through the shared ALU
    function automatic logic is_multicycle(input logic [4:0] opcode);
        return (opcode == ALU_MUL) || (opcode == ALU_DIV);
    endfunction

    function automatic bit mc_cycles_ok(input int n);
        return (n >= MC_CYCLES_MIN) && (n <= MC_CYCLES_MAX);
    endfunction

endpackage

// File: rtl/core_alu_arb.sv
// rtl/core_alu_arb.sv - round-robin arbiter and multicycle sequencer for the shared core ALU
module core_alu_arb
    import core_alu_arb_pkg::*;
#(
    parameter int MC_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req0_valid_i,
    input  logic [4:0]  req0_opcode_i,
    input  logic [7:0]  req0_op1_i,
    input  logic [7:0]  req0_op2_i,
    input  logic        req0_cy_i,
    input  logic        req0_ac_i,
    input  logic        req0_ov_i,
    output logic        req0_ready_o,

    input  logic        req1_valid_i,
    input  logic [4:0]  req1_opcode_i,
    input  logic [7:0]  req1_op1_i,
    input  logic [7:0]  req1_op2_i,
    input  logic        req1_cy_i,
    input  logic        req1_ac_i,
    input  logic        req1_ov_i,
    output logic        req1_ready_o,

    output logic        alu_en_o,
    output logic [7:0]  alu_operand1_o,
    output logic [7:0]  alu_operand2_o,
    output logic [4:0]  alu_opcode_o,
    output logic        alu_cy_o,
    output logic        alu_ac_o,
    output logic        alu_ov_o,
    input  logic [15:0] alu_result_i,
    input  logic        alu_cy_i,
    input  logic        alu_ac_i,
    input  logic        alu_ov_i,

    output logic        rsp_valid_o,
    output logic        rsp_id_o,
    output logic [15:0] rsp_result_o,
    output logic        rsp_cy_o,
    output logic        rsp_ac_o,
    output logic        rsp_ov_o
);

    localparam logic [3:0] MC_LAST = 4'(MC_CYCLES - 1);

    generate
        if (!mc_cycles_ok(MC_CYCLES)) begin : g_bad_mc_cycles
            $error("core_alu_arb: MC_CYCLES must be in 1..15");
        end
    endgenerate

    arb_state_t state;
    logic       last;
    logic       op_id;
    logic [3:0] cnt;

    logic       grant_id;
    logic       accept;
    logic [4:0] sel_opcode;
    logic [7:0] sel_op1;
    logic [7:0] sel_op2;
    logic       sel_cy;
    logic       sel_ac;
    logic       sel_ov;

    // Contention goes to whoever was not served last; a lone requester always wins
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_id = ~last;
        end else if (req1_valid_i) begin
            grant_id = 1'b1;
        end
    end

    assign accept       = ((state == ST_IDLE) || (state == ST_RESP)) && (req0_valid_i || req1_valid_i);
    assign req0_ready_o = accept && !grant_id;
    assign req1_ready_o = accept && grant_id;

    assign sel_opcode = grant_id ? req1_opcode_i : req0_opcode_i;
    assign sel_op1    = grant_id ? req1_op1_i    : req0_op1_i;
    assign sel_op2    = grant_id ? req1_op2_i    : req0_op2_i;
    assign sel_cy     = grant_id ? req1_cy_i     : req0_cy_i;
    assign sel_ac     = grant_id ? req1_ac_i     : req0_ac_i;
    assign sel_ov     = grant_id ? req1_ov_i     : req0_ov_i;

    // The alu_* outputs are the operand register itself, so they hold between operations
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            last           <= 1'b1;
            op_id          <= 1'b0;
            cnt            <= '0;
            alu_en_o       <= 1'b0;
            alu_operand1_o <= '0;
            alu_operand2_o <= '0;
            alu_opcode_o   <= '0;
            alu_cy_o       <= 1'b0;
            alu_ac_o       <= 1'b0;
            alu_ov_o       <= 1'b0;
            rsp_valid_o    <= 1'b0;
            rsp_id_o       <= 1'b0;
            rsp_result_o   <= '0;
            rsp_cy_o       <= 1'b0;
            rsp_ac_o       <= 1'b0;
            rsp_ov_o       <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                ST_EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_valid_o  <= 1'b1;
                        rsp_id_o     <= op_id;
                        rsp_result_o <= alu_result_i;
                        rsp_cy_o     <= alu_cy_i;
                        rsp_ac_o     <= alu_ac_i;
                        rsp_ov_o     <= alu_ov_i;
                        alu_en_o     <= 1'b0;
                        state        <= ST_RESP;
                    end
                end
                default: begin
                    if (accept) begin
                        last           <= grant_id;
                        op_id          <= grant_id;
                        alu_opcode_o   <= sel_opcode;
                        alu_operand1_o <= sel_op1;
                        alu_operand2_o <= sel_op2;
                        alu_cy_o       <= sel_cy;
                        alu_ac_o       <= sel_ac;
                        alu_ov_o       <= sel_ov;
                        cnt            <= is_multicycle(sel_opcode) ? MC_LAST : 4'd0;
                        alu_en_o       <= 1'b1;
                        state          <= ST_EXEC;
                    end else begin
                        alu_en_o <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
